// File: rtl/prescaled_updown_counter.sv
// Up/down event counter stepped by an internal clk prescaler tick.
// Runtime modulus [0, mod_max], wrap or saturate, synchronous load, terminal-count pulse.
module prescaled_updown_counter #(
   parameter int CNT_W     = 8,
   parameter int PRESC_W   = 32,
   parameter int PRESC_DIV = 50000000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             dir,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic [CNT_W-1:0] mod_max,
   output logic [CNT_W-1:0] count,
   output logic             tick,
   output logic             tc
);

   localparam logic [PRESC_W-1:0] P_LAST = PRESC_W'(PRESC_DIV - 1);

   logic [PRESC_W-1:0] r_presc;
   logic [CNT_W-1:0]   r_count;
   logic               r_tick;
   logic               r_tc;

   logic               w_step;
   logic [CNT_W-1:0]   w_next_count;
   logic               w_bound;
   logic [CNT_W-1:0]   w_load_clamped;

   assign w_step         = en && (r_presc == P_LAST);
   assign w_load_clamped = (load_val > mod_max) ? mod_max : load_val;

   // Bound checks come before +1/-1, so the arithmetic can never overflow.
   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      w_next_count = r_count;
      w_bound      = 1'b0;
      if (dir) begin
         if (r_count >= mod_max) begin
            w_bound      = 1'b1;
            w_next_count = sat_mode ? mod_max : '0;
         end else begin
            w_next_count = r_count + 1'b1;
         end
      end else begin
         if (r_count == '0) begin
            w_bound      = 1'b1;
            w_next_count = sat_mode ? '0 : mod_max;
         end else if (r_count > mod_max) begin
            w_next_count = mod_max;
         end else begin
            w_next_count = r_count - 1'b1;
         end
      end
   end

   // NOTE: non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_presc <= '0;
         r_count <= '0;
         r_tick  <= 1'b0;
         r_tc    <= 1'b0;
      end else if (load) begin
         // Load wins over a coincident step, which is dropped.
         r_presc <= '0;
         r_count <= w_load_clamped;
         r_tick  <= 1'b0;
         r_tc    <= 1'b0;
      end else if (!en) begin
         r_tick  <= 1'b0;
         r_tc    <= 1'b0;
      end else if (w_step) begin
         r_presc <= '0;
         r_count <= w_next_count;
         r_tick  <= 1'b1;
         r_tc    <= w_bound;
      end else begin
         r_presc <= r_presc + 1'b1;
         r_tick  <= 1'b0;
         r_tc    <= 1'b0;
      end
   end

   assign count = r_count;
   assign tick  = r_tick;
   assign tc    = r_tc;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench: DUT a uses PRESC_DIV=4, DUT b uses PRESC_DIV=1.
// Expected values are hand-computed constants in the stimulus sequence.
module tb_prescaled_updown_counter;

   logic       clk = 1'b0;
   logic       reset;
   logic       en, dir, sat_mode, load;
   logic [7:0] load_val, mod_max;
   logic [7:0] count;
   logic       tick, tc;

   logic       b_en, b_dir;
   logic [7:0] b_mod;
   logic [7:0] b_count;
   logic       b_tick, b_tc;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   prescaled_updown_counter #(.CNT_W(8), .PRESC_W(32), .PRESC_DIV(4)) u_dut_a (
      .clk(clk), .reset(reset), .en(en), .dir(dir), .sat_mode(sat_mode),
      .load(load), .load_val(load_val), .mod_max(mod_max),
      .count(count), .tick(tick), .tc(tc)
   );

   prescaled_updown_counter #(.CNT_W(8), .PRESC_W(32), .PRESC_DIV(1)) u_dut_b (
      .clk(clk), .reset(reset), .en(b_en), .dir(b_dir), .sat_mode(1'b0),
      .load(1'b0), .load_val(8'd0), .mod_max(b_mod),
      .count(b_count), .tick(b_tick), .tc(b_tc)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle before sampling.
   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // One full period on DUT a: three quiet cycles, then the step.
   task automatic run_period(input string tag, input int exp_count, input int exp_tc);
      for (int i = 0; i < 3; i++) begin
         edge1();
         check({tag, " quiet tick"}, tick, 0);
         check({tag, " quiet tc"}, tc, 0);
      end
      edge1();
      check({tag, " tick"}, tick, 1);
      check({tag, " count"}, count, exp_count);
      check({tag, " tc"}, tc, exp_tc);
   endtask

   task automatic b_step(input string tag, input int exp_count, input int exp_tc);
      edge1();
      check({tag, " tick"}, b_tick, 1);
      check({tag, " count"}, b_count, exp_count);
      check({tag, " tc"}, b_tc, exp_tc);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; dir = 1'b1; sat_mode = 1'b0; load = 1'b0;
      load_val = 8'd0; mod_max = 8'd9;
      b_en = 1'b0; b_dir = 1'b1; b_mod = 8'd3;
      edge1();
      edge1();
      check("reset count", count, 0);
      check("reset tick", tick, 0);
      check("reset tc", tc, 0);

      // 1: up wrap, mod 9
      reset = 1'b0; en = 1'b1;
      for (int k = 1; k <= 9; k++) run_period("up wrap", k, 0);
      run_period("up wrap terminal", 0, 1);

      // 2: down wrap from 0, then down sat pinned at 0
      dir = 1'b0;
      run_period("down wrap", 9, 1);
      run_period("down 8", 8, 0);
      run_period("down 7", 7, 0);
      load = 1'b1; load_val = 8'd0;
      edge1();
      check("load0 count", count, 0);
      check("load0 tick", tick, 0);
      load = 1'b0; sat_mode = 1'b1;
      run_period("down sat a", 0, 1);
      run_period("down sat b", 0, 1);

      // 3: up sat, mod 5
      dir = 1'b1; mod_max = 8'd5;
      for (int k = 1; k <= 5; k++) run_period("up sat", k, 0);
      run_period("up sat pin a", 5, 1);
      run_period("up sat pin b", 5, 1);

      // 4: load coincident with the terminal cycle, clamped to mod_max
      mod_max = 8'd9; sat_mode = 1'b0;
      edge1(); edge1(); edge1();
      check("pre-load tick", tick, 0);
      load = 1'b1; load_val = 8'd200;
      edge1();
      check("load clamp count", count, 9);
      check("load tick", tick, 0);
      check("load tc", tc, 0);
      load = 1'b0;
      run_period("after load", 0, 1);

      // 5: enable hold mid-period at prescaler=2
      edge1(); edge1();
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         edge1();
         check("hold tick", tick, 0);
         check("hold count", count, 0);
      end
      en = 1'b1;
      edge1();
      check("resume quiet tick", tick, 0);
      edge1();
      check("resume tick", tick, 1);
      check("resume count", count, 1);

      // down step with count above a lowered mod_max: clamp, no tc
      load = 1'b1; load_val = 8'd9;
      edge1();
      load = 1'b0; mod_max = 8'd5; dir = 1'b0;
      run_period("down clamp", 5, 0);

      // 6: reset mid-period with count=7
      dir = 1'b1; mod_max = 8'd9;
      load = 1'b1; load_val = 8'd7;
      edge1();
      check("load7 count", count, 7);
      load = 1'b0;
      edge1();
      reset = 1'b1;
      edge1();
      check("midreset count", count, 0);
      check("midreset tick", tick, 0);
      check("midreset tc", tc, 0);
      reset = 1'b0;
      run_period("post reset", 1, 0);

      // PRESC_DIV=1: step on every enabled cycle
      b_en = 1'b1;
      b_step("div1 a", 1, 0);
      b_step("div1 b", 2, 0);
      b_step("div1 c", 3, 0);
      b_step("div1 wrap", 0, 1);
      b_step("div1 d", 1, 0);
      b_mod = 8'd0;
      b_step("mod0 a", 0, 1);
      b_step("mod0 b", 0, 1);
      b_mod = 8'd3;
      b_step("div1 e", 1, 0);
      b_step("div1 f", 2, 0);
      b_mod = 8'd1; b_dir = 1'b0;
      b_step("div1 down clamp", 1, 0);
      b_step("div1 down", 0, 0);
      b_step("div1 down wrap", 1, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/prescaled_updown_counter.md
Name: prescaled_updown_counter

Overview:
Parametrised event counter driven by an internal clock prescaler. The prescaler divides clk by PRESC_DIV to produce a one-cycle tick. On each tick the main counter steps up or down, within a runtime modulus, in wrap or saturate mode. Supports synchronous load and enable, and flags terminal-count events. Used for slow visible counters (LED/seven-segment) and timed event sequencing in board-level designs.

Parameters:
CNT_W, 8, width of main counter and of mod_max/load_val.
PRESC_W, 32, width of prescaler register; must satisfy 2^PRESC_W >= PRESC_DIV.
PRESC_DIV, 50000000, tick period in clk cycles (>=1).

Ports:
clk  in  1  system clock, all logic on rising edge.
reset  in  1  synchronous, active-high.
en  in  1  1 = prescaler runs; 0 = prescaler and counter hold.
dir  in  1  1 = count up, 0 = count down.
sat_mode  in  1  1 = saturate at bounds, 0 = wrap.
load  in  1  synchronous load strobe.
load_val  in  CNT_W  value loaded on load.
mod_max  in  CNT_W  upper bound of count range [0, mod_max].
count  out  CNT_W  current count value, registered.
tick  out  1  registered one-cycle pulse marking each prescaler terminal.
tc  out  1  registered one-cycle pulse on a bound event.

Behaviour:
- Reset is synchronous, active-high, clock clk. At reset: prescaler=0, count=0, tick=0, tc=0. Reset has priority over all other inputs, including mid-period.
- Prescaler:
  - When en=1, the prescaler counts 0..PRESC_DIV-1.
  - On the edge where prescaler==PRESC_DIV-1 and en=1, the prescaler goes to 0 and a step occurs.
  - Tick period is exactly PRESC_DIV cycles. PRESC_DIV=1 gives a step on every enabled cycle.
  - When en=0, the prescaler, count, tick and tc hold. tick and tc are forced to 0.
- Step, applied on the same edge:
  - count updates, tick=1 for one cycle.
  - tick and tc are 0 in every cycle without a step.
- Up step (dir=1):
  - If count>=mod_max, the step is a bound event: wrap → count=0; sat → count=mod_max.
  - Otherwise count+1.
- Down step (dir=0):
  - If count==0, the step is a bound event: wrap → count=mod_max; sat → count stays 0.
  - If count>mod_max, count=mod_max with no tc.
  - Otherwise count-1.
- tc=1 in the cycle after any bound event, in both wrap and sat modes. In sat mode tc repeats on every step while pinned at the bound.
- Load:
  - load=1 (regardless of en) sets count=min(load_val, mod_max) and clears the prescaler to 0.
  - tick=0 and tc=0 that cycle.
  - load has priority over a coincident step; that step is lost.
- Arithmetic is unsigned. No intermediate overflow, because bound checks precede +1/-1.
- mod_max may change at any time and takes effect at the next step. mod_max=0: every step is a bound event; count stays 0.
- dir, sat_mode and mod_max are sampled only on step edges.
- Latency: count, tick and tc reflect a step on the same clock edge as the prescaler terminal. load takes effect one edge after assertion.

Test Plan:
1. PRESC_DIV=4, mod_max=9, dir=1, sat=0, en=1 after reset → tick every 4th cycle; count 0→9 then 0 with tc=1 on that cycle; tick spacing exactly 4 cycles.
2. Same config, dir=0 from count=0 → first step gives count=9 with tc=1, then 8, 7; sat=1 from count=0 → count stays 0, tc on every step.
3. Up with sat=1, mod_max=5 → count 0..5 then holds at 5; tc pulses each subsequent tick; tick continues.
4. load=1, load_val=200, mod_max=9 coincident with a tick → count=9, tick=0, prescaler restarts; next tick exactly 4 cycles later.
5. en=0 for 10 cycles mid-period at prescaler=2 → count, prescaler frozen, no tick; after en=1, tick after 2 more cycles.
6. reset asserted mid-period with count=7 → next edge count=0, tick=0, tc=0; PRESC_DIV=1 → count increments every cycle, tick constantly 1.
